// File: rtl/arbiter_wrr_pkg.sv
// Shared definitions for the weighted round-robin arbiter and its users
// (crossbar address channel, DMA port muxes).
//   ROT_LSB_FIRST : default rotation direction / tie-break (1 = port 0 first)
//   arb_state_e   : arbiter FSM state encoding
//   weight_lsb()  : bit offset of port p's weight in a flat weight bus
package arbiter_wrr_pkg;

  localparam bit ROT_LSB_FIRST = 1'b1;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_e;

  function automatic int unsigned weight_lsb(input int unsigned port,
                                             input int unsigned width);
    return port * width;
  endfunction

endpackage

// File: rtl/priority_enc.sv
// Combinational fixed-priority encoder.
//   req    : request vector
//   onehot : one-hot winner (0 when req == 0)
//   idx    : winner index (0 when req == 0)
//   valid  : any request present
// LSB_HIGH_PRIORITY = 1 picks the lowest set bit, 0 the highest.
module priority_enc
  import arbiter_wrr_pkg::*;
#(
  parameter int  WIDTH             = 4,
  parameter bit  LSB_HIGH_PRIORITY = ROT_LSB_FIRST,
  localparam int IDXW              = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] req,
  output logic [WIDTH-1:0] onehot,
  output logic [IDXW-1:0]  idx,
  output logic             valid
);

  // Scan from the lowest-priority end so the last hit written is the winner.
  always_comb begin
    onehot = '0;
    idx    = '0;
    valid  = 1'b0;
    if (LSB_HIGH_PRIORITY) begin
      for (int i = WIDTH - 1; i >= 0; i--) begin
        if (req[i]) begin
          onehot    = '0;
          onehot[i] = 1'b1;
          idx       = IDXW'(i);
          valid     = 1'b1;
        end
      end
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (req[i]) begin
          onehot    = '0;
          onehot[i] = 1'b1;
          idx       = IDXW'(i);
          valid     = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/arbiter_wrr.sv
// Weighted round-robin arbiter with acknowledge-based grant hold.
//   clk, rst_n     : clock, async active-low reset
//   request        : per-port request level, held until served
//   acknowledge    : per-port transaction-complete pulse (grantee only)
//   weight         : per-port weight, port i at [i*WEIGHT_WIDTH +: WEIGHT_WIDTH]
//   grant          : registered one-hot grant
//   grant_valid    : a grant is active
//   grant_encoded  : grantee index, 0 when idle
// A grantee holds the resource for up to weight[g] acknowledged transactions
// (weight 0 acts as 1), then priority rotates past it.
module arbiter_wrr
  import arbiter_wrr_pkg::*;
#(
  parameter int  PORTS             = 4,
  parameter int  WEIGHT_WIDTH      = 4,
  parameter bit  LSB_HIGH_PRIORITY = ROT_LSB_FIRST,
  localparam int IDXW              = $clog2(PORTS)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [PORTS-1:0]              request,
  input  logic [PORTS-1:0]              acknowledge,
  input  logic [PORTS*WEIGHT_WIDTH-1:0] weight,
  output logic [PORTS-1:0]              grant,
  output logic                          grant_valid,
  output logic [IDXW-1:0]               grant_encoded
);

  localparam logic [IDXW-1:0] PTR_RST = LSB_HIGH_PRIORITY ? IDXW'(PORTS - 1) : '0;

  arb_state_e              state_q, state_d;
  logic [PORTS-1:0]        grant_q, grant_d;
  logic [IDXW-1:0]         enc_q, enc_d;
  logic [IDXW-1:0]         ptr_q, ptr_d;
  logic [WEIGHT_WIDTH-1:0] credit_q, credit_d;

  logic [PORTS-1:0][WEIGHT_WIDTH-1:0] weight_arr;

  for (genvar p = 0; p < PORTS; p++) begin : g_wslice
    assign weight_arr[p] = weight[weight_lsb(p, WEIGHT_WIDTH) +: WEIGHT_WIDTH];
  end

  // Ports strictly after the last grantee in rotation order.
  logic [PORTS-1:0] rot_mask, req_masked;

  always_comb begin
    rot_mask = '0;
    for (int i = 0; i < PORTS; i++)
      rot_mask[i] = LSB_HIGH_PRIORITY ? (i > int'(ptr_q)) : (i < int'(ptr_q));
  end

  assign req_masked = request & rot_mask;

  logic [PORTS-1:0] m_oh, u_oh;
  logic [IDXW-1:0]  m_idx, u_idx;
  logic             m_vld, u_vld;

  priority_enc #(.WIDTH(PORTS), .LSB_HIGH_PRIORITY(LSB_HIGH_PRIORITY)) u_enc_masked (
    .req(req_masked), .onehot(m_oh), .idx(m_idx), .valid(m_vld)
  );

  priority_enc #(.WIDTH(PORTS), .LSB_HIGH_PRIORITY(LSB_HIGH_PRIORITY)) u_enc_unmasked (
    .req(request), .onehot(u_oh), .idx(u_idx), .valid(u_vld)
  );

  // Unmasked fallback covers wrap-around and a lone requester re-winning.
  logic [PORTS-1:0]        win_oh;
  logic [IDXW-1:0]         win_idx;
  logic                    win_vld;
  logic [WEIGHT_WIDTH-1:0] win_w, load_credit;

  assign win_oh      = m_vld ? m_oh : u_oh;
  assign win_idx     = m_vld ? m_idx : u_idx;
  assign win_vld     = u_vld;
  assign win_w       = weight_arr[win_idx];
  assign load_credit = (win_w == '0) ? WEIGHT_WIDTH'(1) : win_w;

  logic gnt_req, gnt_ack, in_grant, do_release, do_keep;

  assign in_grant   = (state_q == ST_GRANT);
  assign gnt_req    = request[enc_q];
  assign gnt_ack    = acknowledge[enc_q];
  // An ack coinciding with a request drop is a single release.
  assign do_release = in_grant && (!gnt_req || (gnt_ack && credit_q == WEIGHT_WIDTH'(1)));
  assign do_keep    = in_grant && gnt_req && gnt_ack && (credit_q > WEIGHT_WIDTH'(1));

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    enc_d    = enc_q;
    ptr_d    = ptr_q;
    credit_d = credit_q;
    if (!in_grant || do_release) begin
      if (win_vld) begin
        state_d  = ST_GRANT;
        grant_d  = win_oh;
        enc_d    = win_idx;
        ptr_d    = win_idx;
        credit_d = load_credit;
      end else begin
        // Pointer is left alone so fairness survives idle periods.
        state_d  = ST_IDLE;
        grant_d  = '0;
        enc_d    = '0;
        credit_d = '0;
      end
    end else if (do_keep) begin
      credit_d = credit_q - WEIGHT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      grant_q  <= '0;
      enc_q    <= '0;
      ptr_q    <= PTR_RST;
      credit_q <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      enc_q    <= enc_d;
      ptr_q    <= ptr_d;
      credit_q <= credit_d;
    end
  end

  assign grant         = grant_q;
  assign grant_valid   = (state_q == ST_GRANT);
  assign grant_encoded = enc_q;

endmodule

// File: tb/tb_arbiter_wrr.sv
// Directed table-driven bench for arbiter_wrr (PORTS=4, WEIGHT_WIDTH=4, LSB first).
// Each row: optional reset, inputs applied at negedge, outputs checked 1ns after
// the following posedge.
module tb_arbiter_wrr;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  request = '0;
  logic [3:0]  acknowledge = '0;
  logic [15:0] weight = '0;
  logic [3:0]  grant;
  logic        grant_valid;
  logic [1:0]  grant_encoded;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  arbiter_wrr #(.PORTS(4), .WEIGHT_WIDTH(4), .LSB_HIGH_PRIORITY(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .request(request), .acknowledge(acknowledge),
    .weight(weight), .grant(grant), .grant_valid(grant_valid),
    .grant_encoded(grant_encoded)
  );

  typedef struct {
    bit          rst;
    string       tag;
    logic [3:0]  req;
    logic [3:0]  ack;
    logic [15:0] w;
    logic [3:0]  g;
    logic [1:0]  e;
    logic        v;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input bit rst, input string tag, input logic [3:0] req,
                     input logic [3:0] ack, input logic [15:0] w,
                     input logic [3:0] g, input logic [1:0] e, input logic v);
    vec_t t;
    t.rst = rst; t.tag = tag; t.req = req; t.ack = ack; t.w = w;
    t.g = g; t.e = e; t.v = v;
    vecs.push_back(t);
  endtask

  task automatic check(input string name, input logic [3:0] g,
                       input logic [1:0] e, input logic v);
    checks++;
    if ({grant, grant_encoded, grant_valid} !== {g, e, v}) begin
      failures++;
      $display("FAIL %s: got grant=%b enc=%0d valid=%b, want grant=%b enc=%0d valid=%b",
               name, grant, grant_encoded, grant_valid, g, e, v);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    request = '0;
    acknowledge = '0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  localparam logic [15:0] W1  = 16'h1111;  // all weights 1
  localparam logic [15:0] W2  = 16'h2031;  // {p3,p2,p1,p0} = {2,0,3,1}
  localparam logic [15:0] W3  = 16'h1500;  // p2 = 5, p3 = 1
  localparam logic [15:0] W4  = 16'h1112;  // p0 = 2

  initial begin
    // 1: reset and plain rotation
    add(1, "s1_first", 4'b1111, 4'b0000, W1, 4'b0001, 2'd0, 1);
    add(0, "s1_rot1",  4'b1111, 4'b0001, W1, 4'b0010, 2'd1, 1);
    add(0, "s1_rot2",  4'b1111, 4'b0010, W1, 4'b0100, 2'd2, 1);
    add(0, "s1_rot3",  4'b1111, 4'b0100, W1, 4'b1000, 2'd3, 1);
    add(0, "s1_wrap",  4'b1111, 4'b1000, W1, 4'b0001, 2'd0, 1);
    // 2: weighting, ack on every port every cycle
    add(1, "s2_g0",    4'b1111, 4'b1111, W2, 4'b0001, 2'd0, 1);
    add(0, "s2_g1a",   4'b1111, 4'b1111, W2, 4'b0010, 2'd1, 1);
    add(0, "s2_g1b",   4'b1111, 4'b1111, W2, 4'b0010, 2'd1, 1);
    add(0, "s2_g1c",   4'b1111, 4'b1111, W2, 4'b0010, 2'd1, 1);
    add(0, "s2_g2w0",  4'b1111, 4'b1111, W2, 4'b0100, 2'd2, 1);
    add(0, "s2_g3a",   4'b1111, 4'b1111, W2, 4'b1000, 2'd3, 1);
    add(0, "s2_g3b",   4'b1111, 4'b1111, W2, 4'b1000, 2'd3, 1);
    add(0, "s2_wrap0", 4'b1111, 4'b1111, W2, 4'b0001, 2'd0, 1);
    add(0, "s2_wrap1", 4'b1111, 4'b1111, W2, 4'b0010, 2'd1, 1);
    // 3: request drop mid-grant, then credit reload
    add(1, "s3_g2",    4'b0100, 4'b0000, W3, 4'b0100, 2'd2, 1);
    add(0, "s3_ack1",  4'b1100, 4'b0100, W3, 4'b0100, 2'd2, 1);
    add(0, "s3_ack2",  4'b1100, 4'b0100, W3, 4'b0100, 2'd2, 1);
    add(0, "s3_drop",  4'b1000, 4'b0000, W3, 4'b1000, 2'd3, 1);
    add(0, "s3_reg2",  4'b1100, 4'b1000, W3, 4'b0100, 2'd2, 1);
    for (int i = 0; i < 4; i++)
      add(0, $sformatf("s3_keep%0d", i), 4'b1100, 4'b0100, W3, 4'b0100, 2'd2, 1);
    add(0, "s3_rel5",  4'b1100, 4'b0100, W3, 4'b1000, 2'd3, 1);
    // 4: spurious acknowledges
    add(1, "s4_g0",    4'b1111, 4'b0000, W4, 4'b0001, 2'd0, 1);
    add(0, "s4_spur",  4'b1111, 4'b1010, W4, 4'b0001, 2'd0, 1);
    add(0, "s4_keep",  4'b1111, 4'b0001, W4, 4'b0001, 2'd0, 1);
    add(0, "s4_rel",   4'b1111, 4'b0001, W4, 4'b0010, 2'd1, 1);
    add(1, "s4_idle1", 4'b0000, 4'b1111, W4, 4'b0000, 2'd0, 0);
    add(0, "s4_idle2", 4'b0000, 4'b1111, W4, 4'b0000, 2'd0, 0);
    // 5: idle fairness and solo requester
    add(1, "s5_g1",    4'b0010, 4'b0000, W1, 4'b0010, 2'd1, 1);
    add(0, "s5_idle",  4'b0000, 4'b0000, W1, 4'b0000, 2'd0, 0);
    add(0, "s5_idle2", 4'b0000, 4'b0000, W1, 4'b0000, 2'd0, 0);
    add(0, "s5_wrap0", 4'b0011, 4'b0000, W1, 4'b0001, 2'd0, 1);
    add(0, "s5_solo",  4'b1000, 4'b0000, W1, 4'b1000, 2'd3, 1);
    for (int i = 0; i < 3; i++)
      add(0, $sformatf("s5_solo%0d", i), 4'b1000, 4'b1000, W1, 4'b1000, 2'd3, 1);
    add(0, "s5_g2",    4'b0100, 4'b0000, W1, 4'b0100, 2'd2, 1);
    add(0, "s5_idle3", 4'b0000, 4'b0000, W1, 4'b0000, 2'd0, 0);
    add(0, "s5_ptr2",  4'b1100, 4'b0000, W1, 4'b1000, 2'd3, 1);

    foreach (vecs[k]) begin
      if (vecs[k].rst) begin
        do_reset();
        check({vecs[k].tag, "_rst"}, 4'b0000, 2'd0, 1'b0);
      end else begin
        @(negedge clk);
      end
      request     = vecs[k].req;
      acknowledge = vecs[k].ack;
      weight      = vecs[k].w;
      @(posedge clk);
      #1;
      check(vecs[k].tag, vecs[k].g, vecs[k].e, vecs[k].v);
    end

    // 6: async reset between edges while port 2 holds the grant
    do_reset();
    weight = W1;
    request = 4'b0100;
    acknowledge = '0;
    @(posedge clk);
    #1;
    check("s6_g2", 4'b0100, 2'd2, 1'b1);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("s6_async", 4'b0000, 2'd0, 1'b0);
    @(posedge clk);
    #1;
    check("s6_held", 4'b0000, 2'd0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("s6_regrant", 4'b0100, 2'd2, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
